// File: rtl/average_unpooler.sv
// average_unpooler: nearest-neighbour upsampler for a raster stream of
// signed fixed-point samples. Each pooled input value is replicated into a
// POOL_DIM x POOL_DIM block. The first output row of each block row is
// streamed straight from the input through a hold register, while the row
// is also stored in a line buffer. The remaining POOL_DIM-1 rows are then
// replayed from that buffer.
// Optional feature: define AVERAGE_UNPOOLER_SCALE_EN to add a run-time
// weight. Every output is multiplied by the weight, and the result passes
// through one extra saturating pipeline stage.

module average_unpooler #(
  parameter int IMG_DIM    = 8,
  parameter int KERNEL_DIM = 3,
  parameter int POOL_DIM   = 2,
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            conv_en,
  input  logic [31:0]                     layer_nr,
  input  logic                            input_valid,
  output logic                            input_ready,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] data_in,
`ifdef AVERAGE_UNPOOLER_SCALE_EN
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] weight_in,
  input  logic                            weight_we,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] output_weight,
`endif
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] data_out,
  output logic                            output_valid,
  output logic                            frame_done
);

  localparam int W          = INT_WIDTH + FRAC_WIDTH;
  localparam int IN_DIM_MAX = IMG_DIM / POOL_DIM;
  localparam int AW         = (IN_DIM_MAX > 1) ? $clog2(IN_DIM_MAX) : 1;
  localparam int RW         = $clog2(POOL_DIM);

  // Index of the last column/row for layer 0 and for deeper layers
  localparam logic [AW-1:0] LAST_L0    = AW'(IMG_DIM / POOL_DIM - 1);
  localparam logic [AW-1:0] LAST_LN    = AW'(((IMG_DIM / 2) - KERNEL_DIM + 1) / POOL_DIM - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(POOL_DIM - 1);
  localparam logic [RW-1:0] REP_PENULT = RW'(POOL_DIM - 2);

  typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] col, col_nxt, in_row, in_row_nxt, last_idx, last_idx_nxt;
  logic [AW-1:0] col_inc;
  logic [RW-1:0] rep, rep_nxt, vrep, vrep_nxt;
  logic          hold_active, hold_active_nxt;
  logic          row_full, row_full_nxt;
  logic [W-1:0]  stage_data, stage_data_nxt;
  logic          stage_valid, stage_valid_nxt;
  logic          stage_done, stage_done_nxt;
  logic          accept;
  logic [W-1:0]  line_buf [IN_DIM_MAX];

  // row_full blocks further accepts once the last column of a row is held
  assign input_ready = (state == FILL) && !row_full && (!hold_active || rep == REP_LAST);
  assign accept      = conv_en && input_valid && input_ready;
  assign col_inc     = col + 1'b1;

  // Next-state, counter and registered-output logic
  always_comb begin
    state_nxt       = state;
    col_nxt         = col;
    rep_nxt         = rep;
    vrep_nxt        = vrep;
    in_row_nxt      = in_row;
    last_idx_nxt    = last_idx;
    hold_active_nxt = hold_active;
    row_full_nxt    = row_full;
    stage_data_nxt  = stage_data;
    stage_valid_nxt = 1'b0;
    stage_done_nxt  = 1'b0;
    if (!conv_en) begin
      state_nxt       = IDLE;
      col_nxt         = '0;
      rep_nxt         = '0;
      vrep_nxt        = '0;
      in_row_nxt      = '0;
      hold_active_nxt = 1'b0;
      row_full_nxt    = 1'b0;
      stage_data_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt       = FILL;
          last_idx_nxt    = (layer_nr == 32'd0) ? LAST_L0 : LAST_LN;
          col_nxt         = '0;
          rep_nxt         = '0;
          vrep_nxt        = '0;
          in_row_nxt      = '0;
          hold_active_nxt = 1'b0;
          row_full_nxt    = 1'b0;
        end
        FILL: begin
          if (accept) begin
            stage_data_nxt  = data_in;
            stage_valid_nxt = 1'b1;
            hold_active_nxt = 1'b1;
            rep_nxt         = '0;
            if (col == last_idx) begin
              row_full_nxt = 1'b1;
            end else begin
              col_nxt = col_inc;
            end
          end else if (hold_active) begin
            if (rep != REP_LAST) begin
              rep_nxt         = rep + 1'b1;
              stage_valid_nxt = 1'b1;
            end else if (row_full) begin
              state_nxt       = REPLAY;
              col_nxt         = '0;
              rep_nxt         = '0;
              vrep_nxt        = RW'(1);
              hold_active_nxt = 1'b0;
              row_full_nxt    = 1'b0;
              stage_data_nxt  = line_buf[0];
              stage_valid_nxt = 1'b1;
            end else begin
              hold_active_nxt = 1'b0;
              rep_nxt         = '0;
            end
          end
        end
        REPLAY: begin
          stage_valid_nxt = 1'b1;
          if (rep != REP_LAST) begin
            rep_nxt = rep + 1'b1;
            if (vrep == REP_LAST && col == last_idx && in_row == last_idx && rep == REP_PENULT) begin
              stage_done_nxt = 1'b1;
            end
          end else if (col != last_idx) begin
            col_nxt        = col_inc;
            rep_nxt        = '0;
            stage_data_nxt = line_buf[col_inc];
          end else if (vrep != REP_LAST) begin
            vrep_nxt       = vrep + 1'b1;
            col_nxt        = '0;
            rep_nxt        = '0;
            stage_data_nxt = line_buf[0];
          end else begin
            stage_valid_nxt = 1'b0;
            vrep_nxt        = '0;
            col_nxt         = '0;
            rep_nxt         = '0;
            if (in_row == last_idx) begin
              state_nxt  = IDLE;
              in_row_nxt = '0;
            end else begin
              state_nxt  = FILL;
              in_row_nxt = in_row + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, counter and first output stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      rep         <= '0;
      vrep        <= '0;
      in_row      <= '0;
      last_idx    <= '0;
      hold_active <= 1'b0;
      row_full    <= 1'b0;
      stage_data  <= '0;
      stage_valid <= 1'b0;
      stage_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      col         <= col_nxt;
      rep         <= rep_nxt;
      vrep        <= vrep_nxt;
      in_row      <= in_row_nxt;
      last_idx    <= last_idx_nxt;
      hold_active <= hold_active_nxt;
      row_full    <= row_full_nxt;
      stage_data  <= stage_data_nxt;
      stage_valid <= stage_valid_nxt;
      stage_done  <= stage_done_nxt;
    end
  end

  // Line buffer write; contents need no reset since every row is rewritten before replay
  always_ff @(posedge clk) begin
    if (accept) begin
      line_buf[col] <= data_in;
    end
  end

`ifdef AVERAGE_UNPOOLER_SCALE_EN
  localparam logic [W-1:0] WEIGHT_ONE = {{(INT_WIDTH-1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};
  localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic [W-1:0]          weight;
  logic signed [2*W-1:0] product;
  logic signed [2*W-1:0] shifted;
  logic [W-1:0]          scaled;

  assign product       = $signed({{W{stage_data[W-1]}}, stage_data}) * $signed({{W{weight[W-1]}}, weight});
  assign shifted       = product >>> FRAC_WIDTH;
  assign output_weight = weight;

  // Weight register, defaults to unity gain
  always_ff @(posedge clk) begin
    if (reset) begin
      weight <= WEIGHT_ONE;
    end else if (weight_we) begin
      weight <= weight_in;
    end
  end

  // Clamp the rescaled product into the signed sample range
  always_comb begin
    scaled = shifted[W-1:0];
    if (shifted > SAT_MAX) begin
      scaled = SAT_MAX[W-1:0];
    end else if (shifted < SAT_MIN) begin
      scaled = SAT_MIN[W-1:0];
    end
  end

  // Extra output stage carrying the scaled sample and its flags
  always_ff @(posedge clk) begin
    if (reset || !conv_en) begin
      data_out     <= '0;
      output_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      output_valid <= stage_valid;
      frame_done   <= stage_done;
      if (stage_valid) begin
        data_out <= scaled;
      end
    end
  end
`else
  assign data_out     = stage_data;
  assign output_valid = stage_valid;
  assign frame_done   = stage_done;
`endif

endmodule

// File: tb/tb_average_unpooler.sv
// tb_average_unpooler: scoreboard bench for average_unpooler. Stimulus
// pushes the expected upsampled raster into a queue, and a negedge monitor
// pops and compares every valid output sample. Builds with or without
// AVERAGE_UNPOOLER_SCALE_EN.

module tb_average_unpooler;

  localparam int P  = 2;
  localparam int DW = 16;
`ifdef AVERAGE_UNPOOLER_SCALE_EN
  localparam int LAT_EXP = 2;
`else
  localparam int LAT_EXP = 1;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          conv_en;
  logic [31:0]   layer_nr;
  logic          input_valid;
  logic          input_ready;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          output_valid;
  logic          frame_done;
`ifdef AVERAGE_UNPOOLER_SCALE_EN
  logic [DW-1:0] weight_in;
  logic          weight_we;
  logic [DW-1:0] output_weight;
`endif

  exp_t          expq[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            total_out = 0;
  int            done_count = 0;
  int            accepted = 0;
  bit            abort_req = 0;
  bit            chk_idle = 0;
  logic [DW-1:0] frame_inc [16];
  logic [DW-1:0] frame_neg [16];

  average_unpooler dut (
    .clk          (clk),
    .reset        (reset),
    .conv_en      (conv_en),
    .layer_nr     (layer_nr),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .data_in      (data_in),
`ifdef AVERAGE_UNPOOLER_SCALE_EN
    .weight_in    (weight_in),
    .weight_we    (weight_we),
    .output_weight(output_weight),
`endif
    .data_out     (data_out),
    .output_valid (output_valid),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every valid output sample
  always @(negedge clk) begin
    exp_t e;
    if (chk_idle) begin
      checkOutput("valid_after_done", {31'd0, output_valid}, 32'd0);
      chk_idle = 0;
    end
    if (output_valid) begin
      total_out++;
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", data_out);
      end else begin
        e = expq.pop_front();
        checkOutput("data_out", {16'd0, data_out}, {16'd0, e.data});
        checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.done});
        if (frame_done) begin
          done_count++;
          chk_idle = 1;
          checkOutput("ready_at_done", {31'd0, input_ready}, 32'd0);
        end
      end
    end else if (frame_done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_without_valid: got frame_done=1, expected 0");
    end
  end

  // Reference nearest-neighbour expansion of one pooled frame
  task automatic pushFrame(input logic [DW-1:0] vals [16], input int in_dim);
    int n;
    exp_t e;
    n = in_dim * P;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        e.data = vals[(r / P) * in_dim + (c / P)];
        e.done = (r == n - 1) && (c == n - 1);
        expq.push_back(e);
      end
    end
  endtask

  task automatic pushConst(input logic [DW-1:0] v, input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.data = v;
      e.done = (i == count - 1);
      expq.push_back(e);
    end
  endtask

  task automatic sendSample(input logic [DW-1:0] v);
    bit got;
    got = 0;
    data_in = v;
    input_valid = 1'b1;
    for (int k = 0; k < 300 && !abort_req; k++) begin
      @(negedge clk);
      if (input_ready) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
      accepted++;
    end else if (!abort_req) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ready_timeout: got no input_ready, expected one within 300 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] vals [16], input int n, input int stall_after);
    for (int i = 0; i < n && !abort_req; i++) begin
      sendSample(vals[i]);
      if (i == stall_after) begin
        input_valid = 1'b0;
        repeat (P + LAT_EXP - 1) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          checkOutput("stall_gap", {31'd0, output_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
      end
    end
    input_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int k = 0; k < 2000 && expq.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checkOutput(name, expq.size(), 32'd0);
  endtask

  task automatic restart(input logic [31:0] layer);
    @(posedge clk);
    #1;
    conv_en = 1'b0;
    input_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    layer_nr = layer;
    conv_en = 1'b1;
  endtask

  initial begin
    int base_out;
    int base_done;
    int n;
    frame_neg = '{16'hFF80, 16'h8000, 16'h0001, 16'h7FFF,
                  16'h8000, 16'hFF80, 16'h0100, 16'hFFFF,
                  16'hFE00, 16'h0080, 16'h8001, 16'h0000,
                  16'h1234, 16'hFF80, 16'h8000, 16'hC000};
    for (int i = 0; i < 16; i++) frame_inc[i] = DW'(i + 1);
    reset = 1'b1;
    conv_en = 1'b0;
    layer_nr = 32'd0;
    input_valid = 1'b0;
    data_in = '0;
`ifdef AVERAGE_UNPOOLER_SCALE_EN
    weight_in = '0;
    weight_we = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_data_out", {16'd0, data_out}, 32'd0);
    checkOutput("reset_valid", {31'd0, output_valid}, 32'd0);
    checkOutput("reset_ready", {31'd0, input_ready}, 32'd0);
    checkOutput("reset_done", {31'd0, frame_done}, 32'd0);
`ifdef AVERAGE_UNPOOLER_SCALE_EN
    checkOutput("reset_weight", {16'd0, output_weight}, 32'h0100);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] layer 0 frame, source always valid");
    restart(32'd0);
    pushFrame(frame_inc, 4);
    base_out = total_out;
    base_done = done_count;
    accepted = 0;
    applyStimulus(frame_inc, 16, -1);
    waitDrain("drain_layer0");
    checkOutput("count_layer0", total_out - base_out, 32'd64);
    checkOutput("accepts_layer0", accepted, 32'd16);
    checkOutput("dones_layer0", done_count - base_done, 32'd1);

    $display("[TB] layer 0 frame with a 3-cycle source stall");
    restart(32'd0);
    pushFrame(frame_inc, 4);
    base_out = total_out;
    base_done = done_count;
    accepted = 0;
    applyStimulus(frame_inc, 16, 1);
    waitDrain("drain_stall");
    checkOutput("count_stall", total_out - base_out, 32'd64);
    checkOutput("accepts_stall", accepted, 32'd16);
    checkOutput("dones_stall", done_count - base_done, 32'd1);

    $display("[TB] layer 1 frame, in_dim 1");
    restart(32'd1);
    pushConst(16'h0180, 4);
    base_out = total_out;
    base_done = done_count;
    sendSample(16'h0180);
    input_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!output_valid && n < 10);
    checkOutput("latency", n, LAT_EXP);
    waitDrain("drain_dim1");
    checkOutput("count_dim1", total_out - base_out, 32'd4);
    checkOutput("dones_dim1", done_count - base_done, 32'd1);

    $display("[TB] negative samples");
    restart(32'd0);
    pushFrame(frame_neg, 4);
    base_out = total_out;
    applyStimulus(frame_neg, 16, -1);
    waitDrain("drain_neg");
    checkOutput("count_neg", total_out - base_out, 32'd64);

    $display("[TB] reset during replay of row 2");
    restart(32'd0);
    pushFrame(frame_inc, 4);
    base_out = total_out;
    base_done = done_count;
    fork
      applyStimulus(frame_inc, 16, -1);
      begin
        for (int k = 0; k < 500 && (total_out - base_out) < 42; k++) @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        abort_req = 1;
        @(posedge clk);
        #1;
        expq.delete();
        @(negedge clk);
        checkOutput("abort_valid", {31'd0, output_valid}, 32'd0);
        checkOutput("abort_ready", {31'd0, input_ready}, 32'd0);
        checkOutput("abort_done", {31'd0, frame_done}, 32'd0);
      end
    join
    checkOutput("abort_no_done", done_count - base_done, 32'd0);
    abort_req = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pushFrame(frame_inc, 4);
    base_out = total_out;
    base_done = done_count;
    applyStimulus(frame_inc, 16, -1);
    waitDrain("drain_after_abort");
    checkOutput("count_after_abort", total_out - base_out, 32'd64);
    checkOutput("dones_after_abort", done_count - base_done, 32'd1);

`ifdef AVERAGE_UNPOOLER_SCALE_EN
    $display("[TB] scaling with weight 2.0");
    restart(32'd1);
    weight_in = 16'h0200;
    weight_we = 1'b1;
    @(posedge clk);
    #1;
    weight_we = 1'b0;
    checkOutput("weight_load", {16'd0, output_weight}, 32'h0200);
    pushConst(16'h7FFF, 4);
    sendSample(16'h6400);
    input_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!output_valid && n < 10);
    checkOutput("scaled_latency", n, 32'd2);
    waitDrain("drain_sat");
    pushConst(16'hFE00, 4);
    sendSample(16'hFF00);
    input_valid = 1'b0;
    waitDrain("drain_neg_scale");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
